// File: rtl/jtgng_rom_pkg.sv
// Shared types and constants for the ROM request arbiter.
package jtgng_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;

  localparam logic [1:0] WMASK_NONE = 2'b00;
  localparam logic [1:0] WMASK_LO   = 2'b01;
  localparam logic [1:0] WMASK_HI   = 2'b10;

  // Odd byte addresses land in bits 7:0, even ones in bits 15:8.
  function automatic logic [1:0] byte_mask(input logic odd);
    return odd ? WMASK_LO : WMASK_HI;
  endfunction

endpackage

// File: rtl/jtgng_rr_pick.sv
// Round-robin picker: first pending channel after the last one granted.
module jtgng_rr_pick #(
  parameter int CH = 4,
  localparam int IW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic [CH-1:0] pending,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= CH; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(CH)) cand = cand - (IW+1)'(CH);
      if (!any && pending[cand[IW-1:0]]) begin
        any   = 1'b1;
        grant = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/jtgng_rom_arb.sv
// Shared ROM port arbiter: round-robin channel reads with a one-entry cache
// per channel, plus a one-entry write buffer for the ROM download stream.
module jtgng_rom_arb
  import jtgng_rom_pkg::*;
#(
  parameter int CH = 4,
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    ch_cs,
  input  logic [CH*AW-1:0] ch_addr,
  output logic [CH-1:0]    ch_ok,
  output logic [CH*DW-1:0] ch_dout,
  input  logic             downloading,
  input  logic             romload_wr,
  input  logic [AW:0]      romload_addr,
  input  logic [7:0]       romload_data,
  output logic             romload_ovf,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic [1:0]       mem_wmask,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  arb_state_t    state, state_nx;
  logic [IW-1:0] gnt_q, gnt_nx, last_grant, last_nx, pick;
  logic          any, fill, wr_clear;
  logic          req_nx, we_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] wdata_nx;
  logic [1:0]    wmask_nx;

  logic [AW-1:0] tag  [CH];
  logic [DW-1:0] data [CH];
  logic [AW-1:0] addr_arr [CH];
  logic [CH-1:0] valid, pending;
  logic          dl_q, dl_fall;

  logic          buf_full;
  logic [AW:0]   buf_addr, src_addr;
  logic [7:0]    buf_data, src_data;

  // Treat the cache as empty in the very cycle downloading falls, so no stale
  // hit is reported before the registered clear takes effect.
  assign dl_fall = dl_q & ~downloading;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign addr_arr[i] = ch_addr[i*AW +: AW];
    assign ch_ok[i] = ch_cs[i] & valid[i] & ~dl_fall & ~downloading &
                      (tag[i] == addr_arr[i]);
    assign ch_dout[i*DW +: DW] = data[i];
  end

  assign pending = ch_cs & ~ch_ok & {CH{~downloading}};

  jtgng_rr_pick #(.CH(CH)) u_pick (
    .pending (pending),
    .last    (last_grant),
    .grant   (pick),
    .any     (any)
  );

  // A byte arriving while idle goes straight out without waiting a cycle.
  assign src_addr = buf_full ? buf_addr : romload_addr;
  assign src_data = buf_full ? buf_data : romload_data;

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    last_nx  = last_grant;
    req_nx   = mem_req;
    we_nx    = mem_we;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    wmask_nx = mem_wmask;
    fill     = 1'b0;
    wr_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (buf_full || romload_wr) begin
          state_nx = ST_WRITE;
          req_nx   = 1'b1;
          we_nx    = 1'b1;
          addr_nx  = src_addr[AW:1];
          wdata_nx = {src_data, src_data};
          wmask_nx = byte_mask(src_addr[0]);
        end else if (any) begin
          state_nx = ST_READ;
          req_nx   = 1'b1;
          we_nx    = 1'b0;
          addr_nx  = addr_arr[pick];
          wmask_nx = WMASK_NONE;
          gnt_nx   = pick;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          fill     = 1'b1;
          req_nx   = 1'b0;
          last_nx  = gnt_q;
          state_nx = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          wr_clear = 1'b1;
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt_q      <= '0;
      last_grant <= IW'(CH-1);
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= WMASK_NONE;
    end else begin
      state      <= state_nx;
      gnt_q      <= gnt_nx;
      last_grant <= last_nx;
      mem_req    <= req_nx;
      mem_we     <= we_nx;
      mem_addr   <= addr_nx;
      mem_wdata  <= wdata_nx;
      mem_wmask  <= wmask_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      tag   <= '{default: '0};
      data  <= '{default: '0};
      dl_q  <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (fill) begin
        tag[gnt_q]   <= mem_addr;
        data[gnt_q]  <= mem_rdata;
        valid[gnt_q] <= 1'b1;
      end
      if (dl_fall) valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full    <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      romload_ovf <= 1'b0;
    end else begin
      if (romload_wr && (!buf_full || wr_clear)) begin
        buf_full <= 1'b1;
        buf_addr <= romload_addr;
        buf_data <= romload_data;
      end else if (wr_clear) begin
        buf_full <= 1'b0;
      end
      if (romload_wr && buf_full && !wr_clear) romload_ovf <= 1'b1;
    end
  end

endmodule
